rgb2gray_cfg: RTL and testbench

Parametrised, run-time configurable successor to the fixed-weight RGB565 grey converter in the DVP video path, upstream of the frame-difference motion detector.
- Accepts RGB565 or RGB888 pixels and applies programmable 8-bit luma weights with rounding and saturation.
- Offers four output modes: weighted grey, max-channel, binary threshold, and G bypass.
- Applies configuration only at frame boundaries and reports the valid-pixel count of each completed frame.

---
 rtl/rgb2gray_cfg.sv | 168 ++++++++++++++++
 tb/tb_rgb2gray_cfg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_cfg.sv
// RGB565/RGB888 to 8-bit luma converter with frame-synchronous configuration,
// four output modes and a per-frame valid-pixel counter. Three-cycle latency.
module rgb2gray_cfg #(
    parameter int unsigned IN_FMT  = 0,
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned DEF_KR  = 77,
    parameter int unsigned DEF_KG  = 150,
    parameter int unsigned DEF_KB  = 29,
    parameter int unsigned DEF_THR = 128
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dvp_vsync,
    input  logic                                dvp_href,
    input  logic                                dvp_valid,
    input  logic [((IN_FMT != 0) ? 24 : 16)-1:0] dvp_data,
    input  logic [7:0]                          cfg_kr,
    input  logic [7:0]                          cfg_kg,
    input  logic [7:0]                          cfg_kb,
    input  logic [7:0]                          cfg_thr,
    input  logic [1:0]                          cfg_mode,
    output logic                                gray_valid,
    output logic                                gray_vsync,
    output logic                                gray_href,
    output logic [7:0]                          gray_data,
    output logic [CNT_W-1:0]                    frame_pix_cnt,
    output logic                                cnt_update
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [7:0] r8, g8, b8;

    if (IN_FMT != 0) begin : g_rgb888
        assign r8 = dvp_data[23:16];
        assign g8 = dvp_data[15:8];
        assign b8 = dvp_data[7:0];
    end else begin : g_rgb565
        assign r8 = {dvp_data[15:11], dvp_data[15:13]};
        assign g8 = {dvp_data[10:5], dvp_data[10:9]};
        assign b8 = {dvp_data[4:0], dvp_data[4:2]};
    end

    // Shadow configuration and frame-start detection
    logic       vs_q;
    logic       frame_start;
    logic [7:0] kr_q, kg_q, kb_q, thr_q;
    logic [1:0] mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             cnt_upd_q;

    // Stage 1: expanded pixel plus the shadow config it travels with
    logic       s1_valid_q, s1_href_q, s1_vsync_q;
    logic [7:0] s1_r_q, s1_g_q, s1_b_q;
    logic [7:0] s1_kr_q, s1_kg_q, s1_kb_q, s1_thr_q;
    logic [1:0] s1_mode_q;

    // Stage 2: products, max channel and G
    logic        s2_valid_q, s2_href_q, s2_vsync_q;
    logic [15:0] s2_pr_q, s2_pg_q, s2_pb_q;
    logic [7:0]  s2_mx_q, s2_g_q, s2_thr_q;
    logic [1:0]  s2_mode_q;
    logic [7:0]  mx_d;

    // Stage 3: outputs
    logic       s3_valid_q, s3_href_q, s3_vsync_q;
    logic [7:0] s3_data_q;
    logic [17:0] sum_d;
    logic [9:0]  y_d;
    logic [7:0]  grey_d, data_d;

    assign frame_start = dvp_vsync & ~vs_q;

    always_comb begin
        cnt_d = cnt_q;
        if (frame_start) begin
            cnt_d = CNT_W'(dvp_valid);
        end else if (dvp_valid && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        mx_d = s1_r_q;
        if (s1_g_q > mx_d) mx_d = s1_g_q;
        if (s1_b_q > mx_d) mx_d = s1_b_q;
    end

    always_comb begin
        sum_d  = 18'(s2_pr_q) + 18'(s2_pg_q) + 18'(s2_pb_q) + 18'd128;
        y_d    = sum_d[17:8];
        grey_d = (y_d > 10'd255) ? 8'hFF : y_d[7:0];
        data_d = grey_d;
        case (s2_mode_q)
            2'd0:    data_d = grey_d;
            2'd1:    data_d = s2_mx_q;
            2'd2:    data_d = (grey_d >= s2_thr_q) ? 8'hFF : 8'h00;
            default: data_d = s2_g_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q        <= 1'b0;
            kr_q        <= 8'(DEF_KR);
            kg_q        <= 8'(DEF_KG);
            kb_q        <= 8'(DEF_KB);
            thr_q       <= 8'(DEF_THR);
            mode_q      <= 2'd0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            cnt_upd_q   <= 1'b0;
        end else begin
            vs_q      <= dvp_vsync;
            cnt_q     <= cnt_d;
            cnt_upd_q <= frame_start;
            if (frame_start) begin
                kr_q        <= cfg_kr;
                kg_q        <= cfg_kg;
                kb_q        <= cfg_kb;
                thr_q       <= cfg_thr;
                mode_q      <= cfg_mode;
                frame_cnt_q <= cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0; s1_href_q <= 1'b0; s1_vsync_q <= 1'b0;
            s1_r_q     <= '0;   s1_g_q    <= '0;   s1_b_q     <= '0;
            s1_kr_q    <= '0;   s1_kg_q   <= '0;   s1_kb_q    <= '0;
            s1_thr_q   <= '0;   s1_mode_q <= '0;
            s2_valid_q <= 1'b0; s2_href_q <= 1'b0; s2_vsync_q <= 1'b0;
            s2_pr_q    <= '0;   s2_pg_q   <= '0;   s2_pb_q    <= '0;
            s2_mx_q    <= '0;   s2_g_q    <= '0;   s2_thr_q   <= '0;
            s2_mode_q  <= '0;
            s3_valid_q <= 1'b0; s3_href_q <= 1'b0; s3_vsync_q <= 1'b0;
            s3_data_q  <= '0;
        end else begin
            s1_valid_q <= dvp_valid; s1_href_q <= dvp_href; s1_vsync_q <= dvp_vsync;
            s1_r_q     <= r8;        s1_g_q    <= g8;       s1_b_q     <= b8;
            s1_kr_q    <= kr_q;      s1_kg_q   <= kg_q;     s1_kb_q    <= kb_q;
            s1_thr_q   <= thr_q;     s1_mode_q <= mode_q;

            s2_valid_q <= s1_valid_q; s2_href_q <= s1_href_q; s2_vsync_q <= s1_vsync_q;
            s2_pr_q    <= 16'(s1_r_q) * 16'(s1_kr_q);
            s2_pg_q    <= 16'(s1_g_q) * 16'(s1_kg_q);
            s2_pb_q    <= 16'(s1_b_q) * 16'(s1_kb_q);
            s2_mx_q    <= mx_d;
            s2_g_q     <= s1_g_q;
            s2_thr_q   <= s1_thr_q;
            s2_mode_q  <= s1_mode_q;

            s3_valid_q <= s2_valid_q; s3_href_q <= s2_href_q; s3_vsync_q <= s2_vsync_q;
            s3_data_q  <= data_d;
        end
    end

    assign gray_valid    = s3_valid_q;
    assign gray_href     = s3_href_q;
    assign gray_vsync    = s3_vsync_q;
    assign gray_data     = s3_data_q;
    assign frame_pix_cnt = frame_cnt_q;
    assign cnt_update    = cnt_upd_q;

endmodule

// File: tb/tb_rgb2gray_cfg.sv
// Directed bench for rgb2gray_cfg: an RGB565 instance plus an RGB888 instance
// with a narrow counter so that count saturation is reachable.
module tb_rgb2gray_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        dvp_vsync, dvp_href, dvp_valid;
    logic [15:0] dvp_data;
    logic [23:0] dvp_data24;
    logic [7:0]  cfg_kr, cfg_kg, cfg_kb, cfg_thr;
    logic [1:0]  cfg_mode;

    logic        gray_valid, gray_vsync, gray_href, cnt_update;
    logic [7:0]  gray_data;
    logic [19:0] frame_pix_cnt;

    logic        gray_valid24, gray_vsync24, gray_href24, cnt_update24;
    logic [7:0]  gray_data24;
    logic [3:0]  frame_pix_cnt24;

    int n_checks = 0;
    int n_err    = 0;
    int npix     = 0;

    always #5 clk = ~clk;

    rgb2gray_cfg #(.IN_FMT(0), .CNT_W(20)) u_dut (
        .clk(clk), .rst(rst), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
        .dvp_valid(dvp_valid), .dvp_data(dvp_data),
        .cfg_kr(cfg_kr), .cfg_kg(cfg_kg), .cfg_kb(cfg_kb), .cfg_thr(cfg_thr),
        .cfg_mode(cfg_mode),
        .gray_valid(gray_valid), .gray_vsync(gray_vsync), .gray_href(gray_href),
        .gray_data(gray_data), .frame_pix_cnt(frame_pix_cnt), .cnt_update(cnt_update)
    );

    rgb2gray_cfg #(.IN_FMT(1), .CNT_W(4)) u_dut24 (
        .clk(clk), .rst(rst), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
        .dvp_valid(dvp_valid), .dvp_data(dvp_data24),
        .cfg_kr(cfg_kr), .cfg_kg(cfg_kg), .cfg_kb(cfg_kb), .cfg_thr(cfg_thr),
        .cfg_mode(cfg_mode),
        .gray_valid(gray_valid24), .gray_vsync(gray_vsync24), .gray_href(gray_href24),
        .gray_data(gray_data24), .frame_pix_cnt(frame_pix_cnt24),
        .cnt_update(cnt_update24)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dvp_valid  = 1'b0;
        dvp_href   = 1'b0;
        dvp_data   = 16'h0;
        dvp_data24 = 24'h0;
    endtask

    // One pixel in, then confirm it emerges exactly three edges later.
    task automatic send(input logic [15:0] d, input logic [7:0] exp, input string tag);
        dvp_data = d; dvp_valid = 1'b1; dvp_href = 1'b1; npix++;
        tick();
        idle();
        tick();
        check({tag, "_early"}, 32'(gray_valid), 32'd0);
        tick();
        check(tag, 32'(gray_data), 32'(exp));
        check({tag, "_valid"}, 32'(gray_valid), 32'd1);
        check({tag, "_href"}, 32'(gray_href), 32'd1);
        tick();
    endtask

    task automatic send24(input logic [23:0] d, input logic [7:0] exp, input string tag);
        dvp_data24 = d; dvp_valid = 1'b1; dvp_href = 1'b1; npix++;
        tick();
        idle();
        tick();
        tick();
        check(tag, 32'(gray_data24), 32'(exp));
        check({tag, "_valid"}, 32'(gray_valid24), 32'd1);
        tick();
    endtask

    task automatic vsync_pulse(input logic [7:0] kr, input logic [7:0] kg, input logic [7:0] kb,
                               input logic [7:0] thr, input logic [1:0] mode, input string tag);
        int sat;
        sat = (npix > 15) ? 15 : npix;
        cfg_kr = kr; cfg_kg = kg; cfg_kb = kb; cfg_thr = thr; cfg_mode = mode;
        dvp_vsync = 1'b1;
        tick();
        check({tag, "_upd"}, 32'(cnt_update), 32'd1);
        check({tag, "_cnt"}, 32'(frame_pix_cnt), 32'(npix));
        check({tag, "_cnt24"}, 32'(frame_pix_cnt24), 32'(sat));
        npix = 0;
        dvp_vsync = 1'b0;
        tick();
        check({tag, "_upd_once"}, 32'(cnt_update), 32'd0);
        check({tag, "_vs_early"}, 32'(gray_vsync), 32'd0);
        tick();
        check({tag, "_vs_out"}, 32'(gray_vsync), 32'd1);
        tick();
        check({tag, "_vs_end"}, 32'(gray_vsync), 32'd0);
    endtask

    initial begin
        rst = 1'b1; dvp_vsync = 1'b0; idle();
        cfg_kr = 8'd0; cfg_kg = 8'd0; cfg_kb = 8'd0; cfg_thr = 8'd0; cfg_mode = 2'd0;
        tick();
        tick();
        check("rst_data", 32'(gray_data), 32'd0);
        check("rst_valid", 32'(gray_valid), 32'd0);
        check("rst_href", 32'(gray_href), 32'd0);
        check("rst_vsync", 32'(gray_vsync), 32'd0);
        check("rst_cnt", 32'(frame_pix_cnt), 32'd0);
        check("rst_upd", 32'(cnt_update), 32'd0);
        rst = 1'b0;
        tick();

        // Default weights, first frame start reports zero pixels
        vsync_pulse(8'd77, 8'd150, 8'd29, 8'd128, 2'd0, "f0");
        send(16'hFFFF, 8'd255, "def_white");
        send(16'hF800, 8'd77,  "def_red");
        send(16'h07E0, 8'd149, "def_green");
        send(16'h001F, 8'd29,  "def_blue");
        send(16'h0000, 8'd0,   "def_black");

        // Saturation of the weighted sum
        vsync_pulse(8'd255, 8'd255, 8'd255, 8'd128, 2'd0, "f1");
        send(16'hFFFF, 8'd255, "sat_white");
        send(16'h0841, 8'd24,  "sat_low");

        // Threshold, max and G-bypass modes
        vsync_pulse(8'd77, 8'd150, 8'd29, 8'd100, 2'd2, "f2");
        send(16'hF800, 8'd0,   "thr_red");
        send(16'h07E0, 8'd255, "thr_green");
        vsync_pulse(8'd77, 8'd150, 8'd29, 8'd100, 2'd1, "f3");
        send(16'h8410, 8'd132, "max_mid");
        vsync_pulse(8'd77, 8'd150, 8'd29, 8'd100, 2'd3, "f4");
        send(16'h07E0, 8'd255, "gbyp_green");

        // Mid-frame config change is ignored until the next frame start
        vsync_pulse(8'd77, 8'd150, 8'd29, 8'd128, 2'd0, "f5");
        cfg_kr = 8'd0;
        send(16'hF800, 8'd77, "midframe_red");
        vsync_pulse(8'd0, 8'd150, 8'd29, 8'd128, 2'd0, "f6");
        send(16'hF800, 8'd0, "newframe_red");

        // Full frame of 64x48 pixels, then a 10-pixel frame
        vsync_pulse(8'd0, 8'd150, 8'd29, 8'd128, 2'd0, "f7");
        for (int row = 0; row < 48; row++) begin
            for (int col = 0; col < 64; col++) begin
                dvp_valid = 1'b1; dvp_href = 1'b1; dvp_data = 16'(col * 97 + row);
                npix++;
                tick();
            end
            idle();
            tick();
        end
        check("frame_model", 32'(npix), 32'd3072);
        vsync_pulse(8'd0, 8'd150, 8'd29, 8'd128, 2'd0, "f8_64x48");
        for (int i = 0; i < 10; i++) begin
            dvp_valid = 1'b1; dvp_href = 1'b1; dvp_data = 16'hAAAA;
            npix++;
            tick();
        end
        idle();
        tick();
        vsync_pulse(8'd0, 8'd150, 8'd29, 8'd128, 2'd0, "f9_10pix");

        // Reset mid-line with pixels in flight
        dvp_valid = 1'b1; dvp_href = 1'b1; dvp_data = 16'hFFFF; npix++;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; idle();
        npix = 0;
        check("midrst_data", 32'(gray_data), 32'd0);
        check("midrst_valid", 32'(gray_valid), 32'd0);
        check("midrst_href", 32'(gray_href), 32'd0);
        check("midrst_cnt", 32'(frame_pix_cnt), 32'd0);
        check("midrst_upd", 32'(cnt_update), 32'd0);
        check("midrst_data24", 32'(gray_data24), 32'd0);
        tick();
        send(16'hF800, 8'd77, "postrst_red");
        send24(24'hFF0000, 8'd77,  "rgb888_red");
        send24(24'h00FF00, 8'd149, "rgb888_green");
        vsync_pulse(8'd77, 8'd150, 8'd29, 8'd128, 2'd0, "f10_postrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
